// File: rtl/ecc_apb_sequencer_if.sv
// APB slave bus bundle for the ECC sequencer.
//
// Handshake: a transfer is offered when PSEL=1 and completes on the rising
// clk edge where PSEL=1, PENABLE=1 and PREADY=1. PRDATA and PSLVERR are only
// meaningful during that access phase.
//
// Signals: PADDR/PSEL/PENABLE/PWRITE/PWDATA driven by the master,
//          PRDATA/PREADY/PSLVERR driven by the slave.
interface ecc_apb_sequencer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// APB register file and single-operation sequencer in front of the ECC core.
//
// A legal CTRL write in IDLE launches one core operation:
//   IDLE -> LAUNCH (core_start) -> WAIT (until core_done or timeout)
//        -> DONE (operation_done) -> IDLE
//
// Register map (PADDR[4:2], other address bits ignored):
//   0 CTRL[1:0] RW        1 DATA_IN RW      2 CODEWORD_WIDTH[1:0] RW
//   3 NOISE RW            4 DATA_OUT RO     5 STATUS RO
//   6,7 unmapped          STATUS = {timeout, num_of_errors[1:0], busy}
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   apb             APB slave bundle (PREADY tied 1, no wait states)
//   core_*          launch, operands and result of the ECC core
//   data_out, num_of_errors   latched result of the last completed operation
//   operation_done  one-cycle pulse in DONE
//   busy            state != IDLE
//   dbg_state       current FSM state encoding (IDLE=0 LAUNCH=1 WAIT=2 DONE=3)
//
// DATA_WIDTH must not exceed AMBA_WORD.
module ecc_apb_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_apb_sequencer_if.slave    apb,
    output logic                  core_start,
    output logic [1:0]            core_mode,
    output logic [1:0]            core_width,
    output logic [DATA_WIDTH-1:0] core_data_in,
    output logic [DATA_WIDTH-1:0] core_noise,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [1:0]            core_num_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_WIDTH  = 3'd2;
    localparam logic [2:0] A_NOISE  = 3'd3;
    localparam logic [2:0] A_DOUT   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    state_t                state_q, state_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [1:0]            width_q, width_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            num_err_q, num_err_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [AMBA_ADDR_WIDTH-1:0] paddr;
    logic [2:0]                 addr;
    logic                       access;
    logic                       wr;
    logic                       rd;
    logic                       wr_err;
    logic                       wr_ok;
    logic [AMBA_WORD-1:0]       rdata;
    logic                       unused_addr;

    assign paddr       = apb.PADDR;
    assign addr        = paddr[4:2];
    assign unused_addr = ^{paddr[AMBA_ADDR_WIDTH-1:5], paddr[1:0]};

    // Reset also forces the bus outputs quiet, so access is masked by rst.
    assign access = apb.PSEL & apb.PENABLE & ~rst;
    assign wr     = access & apb.PWRITE;
    assign rd     = access & ~apb.PWRITE;
    assign busy   = (state_q != S_IDLE);

    // Any write during an operation is refused so that the operands seen by
    // the core stay stable from LAUNCH through WAIT.
    always_comb begin
        wr_err = 1'b0;
        if (busy) begin
            wr_err = 1'b1;
        end else begin
            case (addr)
                A_CTRL:  wr_err = (apb.PWDATA[1:0] == 2'b11);
                A_DATA:  wr_err = 1'b0;
                A_WIDTH: wr_err = (apb.PWDATA[1:0] == 2'b11);
                A_NOISE: wr_err = 1'b0;
                default: wr_err = 1'b1;
            endcase
        end
    end

    assign wr_ok       = wr & ~wr_err;
    assign apb.PSLVERR = wr & wr_err;
    assign apb.PREADY  = 1'b1;

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                A_CTRL:   rdata = AMBA_WORD'(ctrl_q);
                A_DATA:   rdata = AMBA_WORD'(data_in_q);
                A_WIDTH:  rdata = AMBA_WORD'(width_q);
                A_NOISE:  rdata = AMBA_WORD'(noise_q);
                A_DOUT:   rdata = AMBA_WORD'(data_out_q);
                A_STATUS: rdata = AMBA_WORD'({timeout_q, num_err_q, busy});
                default:  rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA = rdata;

    // Next-state and register update logic.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        width_d    = width_q;
        noise_d    = noise_q;
        data_out_d = data_out_q;
        num_err_d  = num_err_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;

        // wr_ok can only be true in IDLE.
        if (wr_ok) begin
            case (addr)
                A_CTRL: begin
                    ctrl_d    = apb.PWDATA[1:0];
                    timeout_d = 1'b0;
                    state_d   = S_LAUNCH;
                end
                A_DATA:  data_in_d = apb.PWDATA[DATA_WIDTH-1:0];
                A_WIDTH: width_d   = apb.PWDATA[1:0];
                A_NOISE: noise_d   = apb.PWDATA[DATA_WIDTH-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: ;
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving in the last allowed cycle still wins
                // over the timeout.
                if (core_done) begin
                    data_out_d = core_data_out;
                    num_err_d  = core_num_err;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            data_in_q  <= '0;
            width_q    <= '0;
            noise_q    <= '0;
            data_out_q <= '0;
            num_err_q  <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            width_q    <= width_d;
            noise_q    <= noise_d;
            data_out_q <= data_out_d;
            num_err_q  <= num_err_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_start     = (state_q == S_LAUNCH);
    assign operation_done = (state_q == S_DONE);
    assign core_mode      = ctrl_q;
    assign core_width     = width_q;
    assign core_data_in   = data_in_q;
    assign core_noise     = noise_q;
    assign data_out       = data_out_q;
    assign num_of_errors  = num_err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
module tb_ecc_apb_sequencer;
    localparam int DW = 32;

    localparam logic [19:0] R_CTRL   = 20'h00;
    localparam logic [19:0] R_DATA   = 20'h04;
    localparam logic [19:0] R_WIDTH  = 20'h08;
    localparam logic [19:0] R_NOISE  = 20'h0C;
    localparam logic [19:0] R_DOUT   = 20'h10;
    localparam logic [19:0] R_STATUS = 20'h14;

    logic          clk;
    logic          rst;
    logic          core_start;
    logic [1:0]    core_mode;
    logic [1:0]    core_width;
    logic [DW-1:0] core_data_in;
    logic [DW-1:0] core_noise;
    logic          core_done;
    logic [DW-1:0] core_data_out;
    logic [1:0]    core_num_err;
    logic [DW-1:0] data_out;
    logic          operation_done;
    logic [1:0]    num_of_errors;
    logic          busy;
    logic [1:0]    dbg_state;

    ecc_apb_sequencer_if #(.ADDR_W(20), .DATA_W(32)) apb ();

    ecc_apb_sequencer #(
        .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .apb(apb.slave),
        .core_start(core_start), .core_mode(core_mode), .core_width(core_width),
        .core_data_in(core_data_in), .core_noise(core_noise),
        .core_done(core_done), .core_data_out(core_data_out),
        .core_num_err(core_num_err), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- core model ----------------
    logic          core_en = 1'b0;
    logic          pending = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic [1:0]    resp_err  = '0;

    // Answers one cycle after core_start, i.e. in the first WAIT cycle.
    initial begin
        core_done     = 1'b0;
        core_data_out = '0;
        core_num_err  = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (pending) begin
                core_done     = 1'b1;
                core_data_out = resp_data;
                core_num_err  = resp_err;
                pending       = 1'b0;
            end
            if (core_start && core_en) pending = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    int            starts = 0;
    int            dones  = 0;
    int            done_cyc = 0;
    logic [1:0]    mode_s;
    logic [1:0]    width_s;
    logic [DW-1:0] din_s;
    logic [DW-1:0] noise_s;

    always @(negedge clk) begin
        if (core_start) begin
            starts  = starts + 1;
            mode_s  = core_mode;
            width_s = core_width;
            din_s   = core_data_in;
            noise_s = core_noise;
        end
        if (operation_done) begin
            dones    = dones + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    int edge_cyc = 0;

    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        #1;
        err = apb.PSLVERR;
        @(posedge clk);
        #1;
        edge_cyc    = cyc;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        @(negedge clk);
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        #1;
        data = apb.PRDATA;
        @(posedge clk);
        #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        err;
    int          s0;
    int          d0;
    int          e0;

    initial begin
        rst         = 1'b1;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", apb.PRDATA, 32'd0);
        check("rst_pslverr", {31'd0, apb.PSLVERR}, 32'd0);
        rst = 1'b0;

        // Reset state
        check("rst_op_done", {31'd0, operation_done}, 32'd0);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        apb_read(R_STATUS, rd); check("rst_status", rd, 32'h0);
        apb_read(R_DOUT, rd);   check("rst_dout", rd, 32'h0);
        @(negedge clk);
        check("idle_prdata", apb.PRDATA, 32'd0);

        // Encode, 1-cycle core
        core_en = 1'b1; resp_data = 32'h0000A5C3; resp_err = 2'b00;
        apb_write(R_DATA, 32'h000000A5, err); check("wr_data_err", {31'd0, err}, 32'd0);
        apb_write(R_WIDTH, 32'h0, err);       check("wr_width_err", {31'd0, err}, 32'd0);
        apb_read(R_DATA, rd);                 check("rb_data", rd, 32'hA5);
        s0 = starts; d0 = dones;
        apb_write(R_CTRL, 32'h0, err);        check("enc_ctrl_err", {31'd0, err}, 32'd0);
        e0 = edge_cyc;
        wait_idle();
        check("enc_starts", starts - s0, 1);
        check("enc_dones", dones - d0, 1);
        check("enc_latency", done_cyc - e0, 2);
        check("enc_mode", {30'd0, mode_s}, 32'd0);
        check("enc_din", din_s, 32'hA5);
        apb_read(R_DOUT, rd);   check("enc_dout", rd, 32'h0000A5C3);
        apb_read(R_STATUS, rd); check("enc_status", rd, 32'h0);

        // Decode with double error, plus a CTRL write while busy
        resp_data = 32'hDEADBEEF; resp_err = 2'b10;
        apb_write(R_NOISE, 32'h00000011, err); check("wr_noise_err", {31'd0, err}, 32'd0);
        apb_write(R_WIDTH, 32'h2, err);        check("wr_width2_err", {31'd0, err}, 32'd0);
        s0 = starts; d0 = dones;
        apb_write(R_CTRL, 32'h1, err);         check("dec_ctrl_err", {31'd0, err}, 32'd0);
        apb_write(R_CTRL, 32'h0, err);         check("busy_ctrl_err", {31'd0, err}, 32'd1);
        wait_idle();
        check("dec_starts", starts - s0, 1);
        check("dec_dones", dones - d0, 1);
        check("dec_mode", {30'd0, mode_s}, 32'd1);
        check("dec_width", {30'd0, width_s}, 32'd2);
        check("dec_noise", noise_s, 32'h11);
        check("dec_nerr", {30'd0, num_of_errors}, 32'd2);
        apb_read(R_DOUT, rd);   check("dec_dout", rd, 32'hDEADBEEF);
        apb_read(R_STATUS, rd); check("dec_status", rd, 32'h4);
        apb_read(R_CTRL, rd);   check("dec_ctrl_rb", rd, 32'h1);

        // Illegal writes
        s0 = starts;
        apb_write(R_CTRL, 32'h3, err);   check("ill_ctrl_err", {31'd0, err}, 32'd1);
        apb_read(R_CTRL, rd);            check("ill_ctrl_rb", rd, 32'h1);
        apb_write(R_WIDTH, 32'h3, err);  check("ill_width_err", {31'd0, err}, 32'd1);
        apb_read(R_WIDTH, rd);           check("ill_width_rb", rd, 32'h2);
        apb_write(R_DOUT, 32'h12345678, err); check("ill_ro_err", {31'd0, err}, 32'd1);
        apb_read(R_DOUT, rd);            check("ill_ro_rb", rd, 32'hDEADBEEF);
        apb_write(20'h1C, 32'h5, err);   check("ill_unmap_err", {31'd0, err}, 32'd1);
        apb_read(20'h18, rd);            check("unmap_read", rd, 32'h0);
        apb_read(20'h20, rd);            check("alias_ctrl_read", rd, 32'h1);
        @(negedge clk);
        check("ill_no_start", starts - s0, 0);
        check("ill_not_busy", {31'd0, busy}, 32'd0);

        // Clear the error count with a clean encode
        resp_data = 32'h00005A5A; resp_err = 2'b00;
        apb_write(R_CTRL, 32'h0, err); check("enc2_err", {31'd0, err}, 32'd0);
        wait_idle();
        apb_read(R_STATUS, rd); check("enc2_status", rd, 32'h0);

        // Timeout: core never answers
        core_en = 1'b0;
        d0 = dones;
        apb_write(R_CTRL, 32'h0, err); check("to_ctrl_err", {31'd0, err}, 32'd0);
        e0 = edge_cyc;
        apb_read(R_STATUS, rd); check("to_busy_status", rd, 32'h1);
        wait_idle();
        check("to_dones", dones - d0, 1);
        check("to_latency", done_cyc - e0, 9);
        apb_read(R_STATUS, rd); check("to_status", rd, 32'h8);
        apb_read(R_DOUT, rd);   check("to_dout", rd, 32'h00005A5A);

        // Reset during WAIT, stray core_done right after reset
        s0 = starts; d0 = dones;
        apb_write(R_DATA, 32'hCAFE0001, err);
        apb_write(R_CTRL, 32'h1, err); check("rw_ctrl_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rw_in_wait", {30'd0, dbg_state}, 32'd2);
        rst = 1'b1;
        resp_data = 32'hFFFFFFFF; resp_err = 2'b01;
        pending = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_core_start", {31'd0, core_start}, 32'd0);
        repeat (4) @(negedge clk);
        check("rw_no_done", dones - d0, 0);
        check("rw_one_start", starts - s0, 1);
        check("rw_dout_port", data_out, 32'h0);
        apb_read(R_DOUT, rd);   check("rw_dout", rd, 32'h0);
        apb_read(R_STATUS, rd); check("rw_status", rd, 32'h0);
        apb_read(R_DATA, rd);   check("rw_data_in", rd, 32'h0);
        apb_read(R_CTRL, rd);   check("rw_ctrl", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation bound expired");
    end
endmodule

// File: doc/ecc_apb_sequencer.md
Name: ecc_apb_sequencer

Overview:
APB slave register file and operation sequencer placed in front of the ECC encoder/decoder core. It holds the configuration and operands written over APB. A write to CTRL launches one core operation. The block latches the core result and pulses operation_done, which the bus-level checker expects 1 to 3 cycles after the CTRL write.

Parameters:
DATA_WIDTH, 32, core operand/result width (codeword up to 32 bits)
AMBA_ADDR_WIDTH, 20, APB address width
AMBA_WORD, 32, APB data width
TIMEOUT_CYCLES, 8, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
PADDR  in  AMBA_ADDR_WIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/read
PWDATA  in  AMBA_WORD  APB write data
PRDATA  out  AMBA_WORD  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  APB error
core_start  out  1  one-cycle launch pulse to ECC core
core_mode  out  2  00 encode, 01 decode, 10 full channel
core_width  out  2  00=8, 01=16, 10=32 bit codeword
core_data_in  out  DATA_WIDTH  operand
core_noise  out  DATA_WIDTH  noise vector
core_done  in  1  core result valid (single cycle)
core_data_out  in  DATA_WIDTH  core result
core_num_err  in  2  00 none, 01 one corrected, 10 two detected
data_out  out  DATA_WIDTH  latched result
operation_done  out  1  one-cycle completion pulse
num_of_errors  out  2  latched error count
busy  out  1  high when state != IDLE

Behaviour:
- APB transfer completes on a clk edge with PSEL&PENABLE=1; PREADY is constant 1, so there are no wait states.
- Decode uses PADDR[4:2]; all other address bits are ignored.
  - 0 CTRL[1:0] RW
  - 1 DATA_IN RW
  - 2 CODEWORD_WIDTH[1:0] RW
  - 3 NOISE RW
  - 4 DATA_OUT RO
  - 5 STATUS RO {timeout[3], num_of_errors[2:1], busy[0]}
  - 6,7 unmapped
- PRDATA is driven in the same cycle as the access phase (combinational mux of registers) and is 0 outside access or for unmapped reads.
- PSLVERR=1, combinational, during the access phase only, for any of:
  - write to an RO or unmapped address
  - write while busy
  - write of CTRL=11 or CODEWORD_WIDTH=11
- An erroring write changes no state.
- FSM states IDLE, LAUNCH, WAIT, DONE:
  - IDLE: a legal CTRL write -> LAUNCH; CTRL is latched and timeout is cleared.
  - LAUNCH (1 cycle): core_start=1. core_mode/width/data_in/noise are driven from the registers, stable from LAUNCH through WAIT. -> WAIT.
  - WAIT: core_done=1 -> capture core_data_out into data_out and core_num_err into num_of_errors on that edge, -> DONE.
  - WAIT: counter reaches TIMEOUT_CYCLES without core_done -> set timeout, leave data_out/num_of_errors unchanged, -> DONE.
  - DONE (1 cycle): operation_done=1. -> IDLE.
- Latency with a 1-cycle core (core_done in the first WAIT cycle):
  - CTRL write completes at edge E.
  - Cycle after E: LAUNCH.
  - Next cycle: WAIT.
  - Next cycle: operation_done=1, which is within 3 cycles of E.
- core_done while in IDLE, LAUNCH or DONE is ignored.
- Reads are always legal, including while busy.
- Back-to-back: a CTRL write in the DONE cycle errors; the first legal write is accepted in IDLE.
- Reset (any state, including mid-operation):
  - state=IDLE
  - all RW registers, data_out, num_of_errors, timeout = 0
  - core_start=0, operation_done=0, busy=0, PSLVERR=0, PRDATA=0
  - a core_done in the cycle after reset is ignored.

Test Plan:
- Reset -> read STATUS=0x0 and DATA_OUT=0x0; operation_done=0, core_start=0.
- Write DATA_IN=0x000000A5, CODEWORD_WIDTH=0, CTRL=0 (encode); model core_done 1 cycle after core_start with data_out=0x0000A5C3, num_err=00 -> core_start exactly 1 cycle, operation_done high exactly 1 cycle at the 3rd cycle after the CTRL edge, DATA_OUT reads 0x0000A5C3, STATUS=0x0.
- Decode with core_num_err=10 -> num_of_errors=2, STATUS reads 0x4; a following CTRL write issued while busy -> PSLVERR=1, no second core_start.
- Illegal writes: CTRL=3, CODEWORD_WIDTH=3, write to 0x10 -> PSLVERR=1 each, register readback unchanged, no launch.
- Core never asserts core_done, TIMEOUT_CYCLES=8 -> operation_done 1 cycle after the 8th WAIT cycle, STATUS=0x8, DATA_OUT unchanged.
- Assert rst during WAIT, then pulse core_done after reset release -> busy=0, data_out=0, no operation_done.
